// File: rtl/adder_sweep_checker.sv
// Exhaustive on-chip checker for an N-bit adder: sweeps every (A, B) pair,
// compares the DUT's {cout, sum} against a golden sum after LAT cycles and reports the result.
module adder_sweep_checker #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned LAT          = 1,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  input  logic               dut_cout,
  input  logic [WIDTH-1:0]   dut_sum,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_cnt,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic [WIDTH:0]     fail_exp
);

  localparam int unsigned VW = 2 * WIDTH;
  localparam int unsigned EW = 2 * WIDTH + 1;
  localparam int unsigned GW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [VW-1:0]      vec_q, vec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [EW-1:0]      err_q, err_d;
  logic [WIDTH-1:0]   fail_a_q, fail_a_d;
  logic [WIDTH-1:0]   fail_b_q, fail_b_d;
  logic [GW-1:0]      fail_exp_q, fail_exp_d;

  // Delay line: each stage holds the issued vector and its valid bit.
  logic [LAT-1:0]          dl_vld_q, dl_vld_d;
  logic [LAT-1:0][VW-1:0]  dl_vec_q, dl_vec_d;

  logic               push_c;
  logic               flush_c;
  logic               tail_vld_c;
  logic [WIDTH-1:0]   tail_a_c;
  logic [WIDTH-1:0]   tail_b_c;
  logic [GW-1:0]      gold_c;
  logic [GW-1:0]      got_c;
  logic               mismatch_c;

  // Golden compare at the delay-line tail; X/Z on the DUT side never matches.
  always_comb begin
    tail_vld_c = dl_vld_q[LAT-1];
    tail_a_c   = dl_vec_q[LAT-1][VW-1:WIDTH];
    tail_b_c   = dl_vec_q[LAT-1][WIDTH-1:0];
    gold_c     = {1'b0, tail_a_c} + {1'b0, tail_b_c};
    got_c      = {dut_cout, dut_sum};
    mismatch_c = tail_vld_c && (got_c !== gold_c);
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    fail_exp_d = fail_exp_q;
    push_c     = 1'b0;
    flush_c    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          vec_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_d      = '0;
          fail_a_d   = '0;
          fail_b_d   = '0;
          fail_exp_d = '0;
          push_c     = 1'b1;
        end
      end
      RUN: begin
        vec_d  = vec_q + VW'(1);
        push_c = 1'b1;
        if (vec_d == '1) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dl_vld_q == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == '0);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (busy_q && mismatch_c) begin
      if (err_q != '1) begin
        err_d = err_q + EW'(1);
      end
      if (err_q == '0) begin
        fail_a_d   = tail_a_c;
        fail_b_d   = tail_b_c;
        fail_exp_d = gold_c;
      end
      // Abort: discard in-flight results so DRAIN finishes on the next edge.
      if (STOP_ON_FAIL) begin
        state_d = DRAIN;
        vec_d   = vec_q;
        push_c  = 1'b0;
        flush_c = 1'b1;
      end
    end
  end

  // Delay-line shift, aligned so the tail meets the DUT result LAT cycles after issue.
  always_comb begin
    dl_vld_d = dl_vld_q;
    dl_vec_d = dl_vec_q;
    for (int i = int'(LAT) - 1; i > 0; i--) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_vec_d[i] = dl_vec_q[i-1];
    end
    dl_vld_d[0] = push_c;
    dl_vec_d[0] = vec_d;
    if (flush_c) begin
      dl_vld_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_exp_q <= '0;
      dl_vld_q   <= '0;
      dl_vec_q   <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      fail_exp_q <= fail_exp_d;
      dl_vld_q   <= dl_vld_d;
      dl_vec_q   <= dl_vec_d;
    end
  end

  assign a_o      = vec_q[VW-1:WIDTH];
  assign b_o      = vec_q[WIDTH-1:0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_a   = fail_a_q;
  assign fail_b   = fail_b_q;
  assign fail_exp = fail_exp_q;

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Directed bench for adder_sweep_checker: several checker instances beside
// ideal, faulty and pipelined adder models, driven from a vector table.
module tb_adder_sweep_checker;

  localparam int W     = 4;
  localparam int LIMIT = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start_v;
  int         mode;
  int         checks = 0;
  int         failures = 0;
  int         both_err = 0;

  always #5 clk = ~clk;

  // Instance 0: LAT=1, sweep all; adder model selected by mode
  logic [W-1:0] a0, b0, s0, fa0, fb0;
  logic         c0, busy0, done0, pass0;
  logic [2*W:0] err0;
  logic [W:0]   fe0, g0, p0_r1, p0_r2;

  // Instance 1: LAT=1, stop on fail; SUM[0] stuck-at-0
  logic [W-1:0] a1, b1, s1, fa1, fb1;
  logic         c1, busy1, done1, pass1;
  logic [2*W:0] err1;
  logic [W:0]   fe1, g1;

  // Instance 2: LAT=3 against an adder with two register stages
  logic [W-1:0] a2, b2, s2, fa2, fb2;
  logic         c2, busy2, done2, pass2;
  logic [2*W:0] err2;
  logic [W:0]   fe2, p2_r1, p2_r2;

  // Instance 3: WIDTH=1 ideal adder
  logic         a3, b3, s3, fa3, fb3, c3, busy3, done3, pass3;
  logic [2:0]   err3;
  logic [1:0]   fe3;

  always_comb begin
    g0 = {1'b0, a0} + {1'b0, b0};
    case (mode)
      1:       g0[0] = 1'b0;
      2:       g0[W] = 1'b0;
      3:       g0 = p0_r2;
      default: ;
    endcase
    {c0, s0} = g0;
    g1 = {1'b0, a1} + {1'b0, b1};
    g1[0] = 1'b0;
    {c1, s1} = g1;
    {c2, s2} = p2_r2;
    {c3, s3} = {1'b0, a3} + {1'b0, b3};
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_r1 <= '0; p0_r2 <= '0; p2_r1 <= '0; p2_r2 <= '0;
    end else begin
      p0_r1 <= {1'b0, a0} + {1'b0, b0};
      p0_r2 <= p0_r1;
      p2_r1 <= {1'b0, a2} + {1'b0, b2};
      p2_r2 <= p2_r1;
    end
  end

  adder_sweep_checker #(.WIDTH(W), .LAT(1), .STOP_ON_FAIL(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a_o(a0), .b_o(b0),
    .dut_cout(c0), .dut_sum(s0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_a(fa0), .fail_b(fb0), .fail_exp(fe0));

  adder_sweep_checker #(.WIDTH(W), .LAT(1), .STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a_o(a1), .b_o(b1),
    .dut_cout(c1), .dut_sum(s1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_a(fa1), .fail_b(fb1), .fail_exp(fe1));

  adder_sweep_checker #(.WIDTH(W), .LAT(3), .STOP_ON_FAIL(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a_o(a2), .b_o(b2),
    .dut_cout(c2), .dut_sum(s2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .fail_a(fa2), .fail_b(fb2), .fail_exp(fe2));

  adder_sweep_checker #(.WIDTH(1), .LAT(1), .STOP_ON_FAIL(1'b0)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .a_o(a3), .b_o(b3),
    .dut_cout(c3), .dut_sum(s3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .fail_a(fa3), .fail_b(fb3), .fail_exp(fe3));

  logic done_v[4], busy_v[4], pass_v[4];
  int   err_v[4], fa_v[4], fb_v[4], fe_v[4], vec_v[4];

  always_comb begin
    done_v[0] = done0; busy_v[0] = busy0; pass_v[0] = pass0;
    done_v[1] = done1; busy_v[1] = busy1; pass_v[1] = pass1;
    done_v[2] = done2; busy_v[2] = busy2; pass_v[2] = pass2;
    done_v[3] = done3; busy_v[3] = busy3; pass_v[3] = pass3;
    err_v[0] = int'(err0); fa_v[0] = int'(fa0); fb_v[0] = int'(fb0); fe_v[0] = int'(fe0);
    err_v[1] = int'(err1); fa_v[1] = int'(fa1); fb_v[1] = int'(fb1); fe_v[1] = int'(fe1);
    err_v[2] = int'(err2); fa_v[2] = int'(fa2); fb_v[2] = int'(fb2); fe_v[2] = int'(fe2);
    err_v[3] = int'(err3); fa_v[3] = int'(fa3); fb_v[3] = int'(fb3); fe_v[3] = int'(fe3);
    vec_v[0] = int'({a0, b0}); vec_v[1] = int'({a1, b1});
    vec_v[2] = int'({a2, b2}); vec_v[3] = int'({a3, b3});
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (busy_v[i] && done_v[i]) both_err++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Start a run on one instance and return the edge after which done rose.
  task automatic run(input int inst, input int mid_edge, output int done_edge,
                     output int order_err);
    int nsz;
    nsz = (inst == 3) ? 4 : 256;
    @(negedge clk);
    start_v[inst] = 1'b1;
    @(posedge clk);
    #1;
    start_v[inst] = 1'b0;
    check("start_busy", int'(busy_v[inst]), 1);
    check("start_done_clr", int'(done_v[inst]), 0);
    done_edge = -1;
    order_err = (vec_v[inst] != 0) ? 1 : 0;
    for (int k = 1; k <= LIMIT; k++) begin
      if (k == mid_edge) start_v[inst] = 1'b1;
      @(posedge clk);
      #1;
      start_v[inst] = 1'b0;
      if (k < nsz && vec_v[inst] != k) order_err++;
      if (done_v[inst]) begin
        done_edge = k;
        break;
      end
    end
  endtask

  typedef struct {
    int inst; int mode; int done_edge; int err; int pass;
    int chk_err; int chk_fail; int fa; int fb; int fe; int chk_order;
  } row_t;

  row_t rows[7];
  int   de, oe;

  initial begin
    rows[0] = '{0, 1, 257, 128, 0, 1, 1, 0,  1,  1, 1};
    rows[1] = '{0, 2, 257, 120, 0, 1, 1, 1, 15, 16, 1};
    rows[2] = '{0, 0, 257,   0, 1, 1, 1, 0,  0,  0, 1};
    rows[3] = '{0, 3, 257,   0, 0, 0, 0, 0,  0,  0, 1};
    rows[4] = '{1, 1,   3,   1, 0, 1, 1, 0,  1,  1, 0};
    rows[5] = '{2, 0, 259,   0, 1, 1, 1, 0,  0,  0, 1};
    rows[6] = '{3, 0,   5,   0, 1, 1, 1, 0,  0,  0, 1};

    rst = 1'b1;
    start_v = '0;
    mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_pass", int'(pass0), 0);
    check("rst_err", err_v[0], 0);
    check("rst_vec", vec_v[0], 0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 7; r++) begin
      mode = rows[r].mode;
      run(rows[r].inst, -1, de, oe);
      check($sformatf("row%0d_done_edge", r), de, rows[r].done_edge);
      check($sformatf("row%0d_busy", r), int'(busy_v[rows[r].inst]), 0);
      check($sformatf("row%0d_pass", r), int'(pass_v[rows[r].inst]), rows[r].pass);
      if (rows[r].chk_err != 0)
        check($sformatf("row%0d_err_cnt", r), err_v[rows[r].inst], rows[r].err);
      if (rows[r].chk_fail != 0) begin
        check($sformatf("row%0d_fail_a", r), fa_v[rows[r].inst], rows[r].fa);
        check($sformatf("row%0d_fail_b", r), fb_v[rows[r].inst], rows[r].fb);
        check($sformatf("row%0d_fail_exp", r), fe_v[rows[r].inst], rows[r].fe);
      end
      if (rows[r].chk_order != 0)
        check($sformatf("row%0d_order", r), oe, 0);
    end

    // done and result are held while idle
    repeat (5) @(posedge clk);
    #1;
    check("done_hold", int'(done3), 1);
    check("pass_hold", int'(pass3), 1);

    // Reset in the middle of a sweep
    mode = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    check("mid_busy", int'(busy0), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy0), 0);
    check("mid_rst_done", int'(done0), 0);
    check("mid_rst_err", err_v[0], 0);
    check("mid_rst_vec", vec_v[0], 0);
    @(negedge clk);
    rst = 1'b0;

    // Second run with a start pulse mid-sweep that must be ignored
    run(0, 50, de, oe);
    check("rerun_done_edge", de, 257);
    check("rerun_pass", int'(pass0), 1);
    check("rerun_err", err_v[0], 0);
    check("rerun_order", oe, 0);

    check("busy_done_excl", both_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
